// File: rtl/reg_bus_master.sv
// Initiator for the single-register config bus: takes one host command, runs it on the bus, returns the response.
// Optional macro REG_MASTER_TIMEOUT_EN adds an ack timeout counter and the rsp_err error path.
module reg_bus_master #(
  parameter int W_WIDTH        = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_wr,
  input  logic [W_WIDTH-1:0] cmd_addr,
  input  logic [W_WIDTH-1:0] cmd_wdata,
  output logic               sel_en,
  output logic               wr_rd_s,
  output logic [W_WIDTH-1:0] addr,
  output logic [W_WIDTH-1:0] wr_data,
  input  logic [W_WIDTH-1:0] rd_data,
  input  logic               ack,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W_WIDTH-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t             state_reg, state_next;
  logic               sel_en_reg, sel_en_next;
  logic               wr_rd_s_reg, wr_rd_s_next;
  logic [W_WIDTH-1:0] addr_reg, addr_next;
  logic [W_WIDTH-1:0] wr_data_reg, wr_data_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic [W_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic               cmd_ready_reg, cmd_ready_next;
  logic               busy_reg, busy_next;

`ifdef REG_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rsp_err_reg, rsp_err_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sel_en_reg    <= 1'b0;
      wr_rd_s_reg   <= 1'b0;
      addr_reg      <= '0;
      wr_data_reg   <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      cmd_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
`ifdef REG_MASTER_TIMEOUT_EN
      cnt_reg       <= '0;
      rsp_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      sel_en_reg    <= sel_en_next;
      wr_rd_s_reg   <= wr_rd_s_next;
      addr_reg      <= addr_next;
      wr_data_reg   <= wr_data_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      cmd_ready_reg <= cmd_ready_next;
      busy_reg      <= busy_next;
`ifdef REG_MASTER_TIMEOUT_EN
      cnt_reg       <= cnt_next;
      rsp_err_reg   <= rsp_err_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    sel_en_next    = sel_en_reg;
    wr_rd_s_next   = wr_rd_s_reg;
    addr_next      = addr_reg;
    wr_data_next   = wr_data_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
`ifdef REG_MASTER_TIMEOUT_EN
    cnt_next       = cnt_reg;
    rsp_err_next   = rsp_err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          wr_rd_s_next = cmd_wr;
          addr_next    = cmd_addr;
          wr_data_next = cmd_wdata;
          sel_en_next  = 1'b1;
          state_next   = REQ;
`ifdef REG_MASTER_TIMEOUT_EN
          cnt_next     = '0;
`endif
        end
      end
      REQ: begin
`ifdef REG_MASTER_TIMEOUT_EN
        if (cnt_reg != CNT_W'(TIMEOUT_CYCLES))
          cnt_next = cnt_reg + CNT_W'(1);
`endif
        // ack takes priority over a timeout firing in the same cycle
        if (ack) begin
          sel_en_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = wr_rd_s_reg ? '0 : rd_data;
          state_next     = RESP;
`ifdef REG_MASTER_TIMEOUT_EN
          rsp_err_next   = 1'b0;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          sel_en_next    = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
          state_next     = RESP;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
`ifdef REG_MASTER_TIMEOUT_EN
          rsp_err_next   = 1'b0;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
    cmd_ready_next = (state_next == IDLE);
    busy_next      = (state_next != IDLE);
  end

  assign sel_en    = sel_en_reg;
  assign wr_rd_s   = wr_rd_s_reg;
  assign addr      = addr_reg;
  assign wr_data   = wr_data_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign cmd_ready = cmd_ready_reg;
  assign busy      = busy_reg;
`ifdef REG_MASTER_TIMEOUT_EN
  assign rsp_err   = rsp_err_reg;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master: scoreboard of expected responses, responder modelled by tasks.
module tb_reg_bus_master;
  localparam int W  = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [W-1:0] cmd_addr = '0, cmd_wdata = '0;
  logic         cmd_ready, sel_en, wr_rd_s, ack = 1'b0;
  logic [W-1:0] addr, wr_data, rd_data = 8'hEE, rsp_rdata;
  logic         rsp_valid, rsp_ready = 1'b0, rsp_err, busy;

  typedef struct {
    logic [W-1:0] rdata;
    logic         err;
  } rsp_t;
  rsp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  reg_bus_master #(.W_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .sel_en(sel_en), .wr_rd_s(wr_rd_s), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .ack(ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction. ack_cycle is the 1-based sel_en cycle carrying ack (0 = never).
  task automatic do_txn(input logic wr, input logic [W-1:0] a, input logic [W-1:0] wd,
                        input int ack_cycle, input logic [W-1:0] rdv, input int bp);
    rsp_t exp;
    int cnt;
    int exp_cnt;
    logic [W-1:0] first_rdata;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = wd;
    exp.err   = (ack_cycle == 0);
    exp.rdata = (wr || ack_cycle == 0) ? '0 : rdv;
    exp_q.push_back(exp);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = ~wd; cmd_wr = ~wr;
    check("sel_en_rise", sel_en, 1);
    check("wr_rd_s", wr_rd_s, wr);
    check("addr", addr, a);
    check("wr_data", wr_data, wd);
    check("cmd_ready_req", cmd_ready, 0);
    cnt = 0;
    while (sel_en === 1'b1 && cnt < 200) begin
      cnt++;
      if (cnt == ack_cycle) begin ack = 1'b1; rd_data = rdv; end
      @(negedge clk);
      ack = 1'b0; rd_data = 8'hEE;
    end
    exp_cnt = (ack_cycle == 0) ? TO : ack_cycle;
    check("sel_en_cycles", cnt, exp_cnt);
    check("addr_hold", addr, a);
    check("rsp_valid_rise", rsp_valid, 1);
    first_rdata = rsp_rdata;
    cmd_valid = (bp > 0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, first_rdata);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_sel_en", sel_en, 0);
    end
    rsp_ready = 1'b1;
    exp = exp_q.pop_front();
    check("rsp_rdata", rsp_rdata, exp.rdata);
    check("rsp_err", rsp_err, exp.err);
    $display("txn wr=%0d addr=%h wdata=%h ack_cycle=%0d bp=%0d -> rdata=%h err=%0d",
             wr, a, wd, ack_cycle, bp, rsp_rdata, rsp_err);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("post_busy", busy, 0);
    check("post_sel_en", sel_en, 0);
    cmd_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_sel_en", sel_en, 0);
    check("rst_wr_rd_s", wr_rd_s, 0);
    check("rst_addr", addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);

    // Write, ack one cycle after sel_en rises
    do_txn(1'b1, 8'h05, 8'hA5, 2, 8'h77, 0);
    // Read, ack on the first sel_en cycle
    do_txn(1'b0, 8'h05, 8'h00, 1, 8'hA5, 0);
`ifdef REG_MASTER_TIMEOUT_EN
    do_txn(1'b0, 8'h3C, 8'h00, 0, 8'h00, 0);
`endif
    // Ack on the last cycle before timeout wins
    do_txn(1'b0, 8'h3C, 8'h00, TO, 8'h5A, 0);
    // Backpressure with a pending command
    do_txn(1'b0, 8'h11, 8'h00, 1, 8'hC3, 5);

    // Reset mid-operation, then a late ack
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h22;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_sel_en", sel_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_sel_en", sel_en, 0);
    check("mrst_rsp_valid", rsp_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_cmd_ready", cmd_ready, 1);
    ack = 1'b1; rd_data = 8'h99;
    @(negedge clk);
    ack = 1'b0;
    check("late_ack_rsp_valid", rsp_valid, 0);
    check("late_ack_busy", busy, 0);
    $display("txn reset-mid-op addr=22 dropped");

    // Stray ack in IDLE
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    check("stray_rsp_valid", rsp_valid, 0);
    check("stray_busy", busy, 0);
    check("stray_sel_en", sel_en, 0);
    check("stray_cmd_ready", cmd_ready, 1);
    $display("txn stray ack ignored");

    // Random mix
    for (int i = 0; i < 6; i++) begin
      do_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
             $urandom_range(1, 4), 8'($urandom), $urandom_range(0, 2));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
Initiator side of the single-register config bus (sel_en / wr_rd_s / addr / wr_data / rd_data / ack) that the per-port config register blocks respond on.
- Accepts one read or write command at a time from a host-side valid/ready interface.
- Drives the bus until the addressed responder pulses ack, or until a timeout expires.
- Returns read data and status on a valid/ready response interface.
- Sits between the switch's management/host logic and the bank of port configuration registers.

Parameters:
W_WIDTH, 8, width of address, write data and read data
TIMEOUT_CYCLES, 16, max cycles sel_en stays high waiting for ack (used only with REG_MASTER_TIMEOUT_EN); must be >= 1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
cmd_valid  input  1  host command valid
cmd_ready  output  1  master can accept a command
cmd_wr  input  1  1 = write, 0 = read
cmd_addr  input  W_WIDTH  target register address
cmd_wdata  input  W_WIDTH  write data (ignored for reads)
sel_en  output  1  bus select/enable to responders
wr_rd_s  output  1  bus direction, 1 = write, 0 = read
addr  output  W_WIDTH  bus address
wr_data  output  W_WIDTH  bus write data
rd_data  input  W_WIDTH  read data from responders (valid when ack = 1)
ack  input  1  responder acknowledge, one-cycle pulse
rsp_valid  output  1  response available
rsp_ready  input  1  host accepts response
rsp_rdata  output  W_WIDTH  captured read data; 0 for writes and errors
rsp_err  output  1  1 = transaction timed out
busy  output  1  1 in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: all outputs are registered. On rst: state = IDLE, sel_en/wr_rd_s/addr/wr_data = 0, rsp_valid/rsp_err/rsp_rdata = 0, timeout counter = 0, cmd_ready = 1, busy = 0.
- State machine: IDLE -> REQ -> RESP -> IDLE.
- IDLE:
  - cmd_ready = 1.
  - On the edge where cmd_valid & cmd_ready: latch cmd_wr, cmd_addr, cmd_wdata onto wr_rd_s, addr, wr_data; set sel_en = 1; clear the counter; go to REQ.
  - sel_en therefore rises in cycle T+1 for a command accepted in cycle T.
- REQ:
  - cmd_ready = 0. sel_en, wr_rd_s, addr and wr_data are held stable.
  - Counter increments each cycle; it is saturating, width $clog2(TIMEOUT_CYCLES+1).
  - ack = 1 sampled (cycle A): next cycle sel_en = 0, rsp_valid = 1, rsp_err = 0. rsp_rdata = rd_data for a read, 0 for a write. Go to RESP.
  - Timeout (feature enabled): the counter reaches TIMEOUT_CYCLES with no ack, i.e. the TIMEOUT_CYCLES-th cycle of sel_en high passes without ack. Next cycle sel_en = 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0. Go to RESP.
  - ack in the same cycle the timeout would fire: ack wins, rsp_err = 0.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid = 0, rsp_err = 0, go to IDLE; cmd_ready = 1 the following cycle.
  - A new command is never accepted while rsp_valid = 1.
- Stray ack: ack in IDLE or RESP is ignored and causes no state change.
- Addr/wr_data after completion: hold their last values after sel_en drops; only sel_en qualifies the bus.
- Best-case throughput: accept (T), sel_en (T+1), ack at T+1, rsp_valid (T+2), rsp_ready at T+2, IDLE at T+3. Minimum 3 cycles per transaction.
- Reset mid-operation: rst has priority in every state. The in-flight transaction is dropped with no response. sel_en is 0 in the cycle after the rst edge.

Optional Feature:
Macro REG_MASTER_TIMEOUT_EN.
- Defined: timeout counter and rsp_err error path exist as described above.
- Undefined: counter logic is absent and REQ waits for ack indefinitely. rsp_err is tied to 0. TIMEOUT_CYCLES is unused.

Test Plan:
1. Write: cmd wr=1 addr=0x05 wdata=0xA5; responder acks 1 cycle after sel_en rises -> sel_en high exactly 2 cycles with wr_rd_s=1, addr=0x05, wr_data=0xA5; rsp_valid=1 with rsp_err=0, rsp_rdata=0x00.
2. Read: cmd wr=0 addr=0x05; responder drives rd_data=0xA5 with ack on the 1st sel_en cycle -> rsp_rdata=0xA5, rsp_err=0, cmd_ready back to 1 the cycle after the rsp handshake.
3. Timeout (macro on, TIMEOUT_CYCLES=16): read addr=0x3C, ack never asserted -> sel_en high exactly 16 cycles; then rsp_valid=1, rsp_err=1, rsp_rdata=0x00. Repeat with ack on the 16th cycle and rd_data=0x5A -> rsp_err=0, rsp_rdata=0x5A.
4. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid with cmd_valid=1 -> rsp_valid/rsp_rdata stable, cmd_ready=0, no new sel_en until 1 cycle after the handshake.
5. Reset mid-operation: assert rst for 1 cycle while sel_en=1 -> next cycle sel_en=0, rsp_valid=0, busy=0, cmd_ready=1. A late ack arriving afterwards produces no response.
6. Stray ack: pulse ack while in IDLE with no command -> no rsp_valid, state remains IDLE.
